// File: rtl/seg7_scan_decoder.sv
// Multiplexed 7-segment bus reader: recovers one BCD digit per strobe position and publishes full frames.
// Optional decimal-point capture (dp input, dp_mask output) is enabled by defining SEG7_DP_EN.
module seg7_scan_decoder #(
  parameter int NDIG       = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg,
  input  logic [NDIG-1:0]     dig_sel,
`ifdef SEG7_DP_EN
  input  logic                dp,
  output logic [NDIG-1:0]     dp_mask,
`endif
  output logic                frame_valid,
  output logic [4*NDIG-1:0]   bcd_out,
  output logic [NDIG-1:0]     blank_mask,
  output logic [NDIG-1:0]     err_mask
);

  localparam int         SW      = 8 + NDIG;
  localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT - 1);

  typedef enum logic [0:0] {COLLECT = 1'b0, PUBLISH = 1'b1} state_t;

  // Returns {blank, err, nibble} for one segment pattern.
  function automatic logic [5:0] decode_seg(input logic [6:0] p);
    logic [5:0] r;
    case (p)
      7'b1111110: r = {2'b00, 4'h0};
      7'b0110000: r = {2'b00, 4'h1};
      7'b1101101: r = {2'b00, 4'h2};
      7'b1111001: r = {2'b00, 4'h3};
      7'b0110011: r = {2'b00, 4'h4};
      7'b1011011: r = {2'b00, 4'h5};
      7'b1011111: r = {2'b00, 4'h6};
      7'b1110010: r = {2'b00, 4'h7};
      7'b1111111: r = {2'b00, 4'h8};
      7'b1111011: r = {2'b00, 4'h9};
      7'b0000000: r = {2'b10, 4'hF};
      default:    r = {2'b01, 4'hE};
    endcase
    return r;
  endfunction

  function automatic logic is_onehot(input logic [NDIG-1:0] v);
    return (v != {NDIG{1'b0}}) && ((v & (v - NDIG'(1'b1))) == {NDIG{1'b0}});
  endfunction

  logic              dp_s;
  logic [SW-1:0]     sample_s;
  logic              onehot_s;
  logic              acc_keep_s;
  logic              accept_s;
  logic [5:0]        dec_s;

  logic [SW-1:0]     prev_q, prev_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              acc_q, acc_d;
  logic [NDIG-1:0]   captured_q, captured_d;
  state_t            state_q, state_d;
  logic [4*NDIG-1:0] stg_bcd_q, stg_bcd_d;
  logic [NDIG-1:0]   stg_blank_q, stg_blank_d;
  logic [NDIG-1:0]   stg_err_q, stg_err_d;
  logic              frame_valid_q, frame_valid_d;
  logic [4*NDIG-1:0] bcd_q, bcd_d;
  logic [NDIG-1:0]   blank_q, blank_d;
  logic [NDIG-1:0]   err_q, err_d;
`ifdef SEG7_DP_EN
  logic [NDIG-1:0]   stg_dp_q, stg_dp_d;
  logic [NDIG-1:0]   dp_mask_q, dp_mask_d;
  assign dp_s = dp;
`else
  assign dp_s = 1'b0;
`endif

  assign sample_s = {seg, dp_s, dig_sel};
  assign onehot_s = is_onehot(dig_sel);
  assign dec_s    = decode_seg(seg);

  // Stability tracking: accept on the STABLE_CNT-th identical one-hot sample, once per run.
  always_comb begin
    prev_d     = sample_s;
    acc_keep_s = 1'b0;
    if (!onehot_s) begin
      cnt_d = 4'd0;
    end else if (sample_s == prev_q) begin
      cnt_d      = (cnt_q < CNT_MAX) ? (cnt_q + 4'd1) : cnt_q;
      acc_keep_s = acc_q;
    end else begin
      cnt_d = 4'd0;
    end
    accept_s = onehot_s && (cnt_d == CNT_MAX) && !acc_keep_s;
    acc_d    = acc_keep_s | accept_s;
  end

  // Staging slots; a repeat acceptance of the same position overwrites it.
  always_comb begin
    stg_bcd_d   = stg_bcd_q;
    stg_blank_d = stg_blank_q;
    stg_err_d   = stg_err_q;
`ifdef SEG7_DP_EN
    stg_dp_d    = stg_dp_q;
`endif
    for (int k = 0; k < NDIG; k++) begin
      if (accept_s && dig_sel[k]) begin
        stg_bcd_d[4*k +: 4] = dec_s[3:0];
        stg_blank_d[k]      = dec_s[5];
        stg_err_d[k]        = dec_s[4];
`ifdef SEG7_DP_EN
        stg_dp_d[k]         = dp_s;
`endif
      end else begin
        stg_bcd_d[4*k +: 4] = stg_bcd_q[4*k +: 4];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    captured_d = captured_q;
    case (state_q)
      COLLECT: begin
        captured_d = captured_q | (accept_s ? dig_sel : {NDIG{1'b0}});
        if (accept_s && (captured_d == {NDIG{1'b1}})) begin
          state_d = PUBLISH;
        end else begin
          state_d = COLLECT;
        end
      end
      PUBLISH: begin
        // An acceptance in this cycle belongs to the next frame.
        captured_d = accept_s ? dig_sel : {NDIG{1'b0}};
        state_d    = COLLECT;
      end
      default: begin
        captured_d = {NDIG{1'b0}};
        state_d    = COLLECT;
      end
    endcase
  end

  always_comb begin
    frame_valid_d = (state_d == PUBLISH);
    bcd_d         = bcd_q;
    blank_d       = blank_q;
    err_d         = err_q;
`ifdef SEG7_DP_EN
    dp_mask_d     = dp_mask_q;
`endif
    if (state_d == PUBLISH) begin
      bcd_d     = stg_bcd_d;
      blank_d   = stg_blank_d;
      err_d     = stg_err_d;
`ifdef SEG7_DP_EN
      dp_mask_d = stg_dp_d;
`endif
    end else begin
      bcd_d     = bcd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q        <= {SW{1'b0}};
      cnt_q         <= 4'd0;
      acc_q         <= 1'b0;
      captured_q    <= {NDIG{1'b0}};
      state_q       <= COLLECT;
      stg_bcd_q     <= {(4*NDIG){1'b0}};
      stg_blank_q   <= {NDIG{1'b0}};
      stg_err_q     <= {NDIG{1'b0}};
      frame_valid_q <= 1'b0;
      bcd_q         <= {(4*NDIG){1'b0}};
      blank_q       <= {NDIG{1'b0}};
      err_q         <= {NDIG{1'b0}};
`ifdef SEG7_DP_EN
      stg_dp_q      <= {NDIG{1'b0}};
      dp_mask_q     <= {NDIG{1'b0}};
`endif
    end else begin
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      captured_q    <= captured_d;
      state_q       <= state_d;
      stg_bcd_q     <= stg_bcd_d;
      stg_blank_q   <= stg_blank_d;
      stg_err_q     <= stg_err_d;
      frame_valid_q <= frame_valid_d;
      bcd_q         <= bcd_d;
      blank_q       <= blank_d;
      err_q         <= err_d;
`ifdef SEG7_DP_EN
      stg_dp_q      <= stg_dp_d;
      dp_mask_q     <= dp_mask_d;
`endif
    end
  end

  assign frame_valid = frame_valid_q;
  assign bcd_out     = bcd_q;
  assign blank_mask  = blank_q;
  assign err_mask    = err_q;
`ifdef SEG7_DP_EN
  assign dp_mask     = dp_mask_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: two instances (STABLE_CNT=3 and 1) on one shared bus, checked
// every cycle against a run-length / frame-table reference model plus directed expectations.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = 7'd0;
  logic [3:0]  dig_sel = 4'd0;
  logic        fv_o    [2];
  logic [15:0] bcd_o   [2];
  logic [3:0]  blank_o [2];
  logic [3:0]  err_o   [2];
`ifdef SEG7_DP_EN
  logic        dp = 1'b0;
  logic [3:0]  dpm_o   [2];
`endif

  always #5 clk = ~clk;

  seg7_scan_decoder #(.NDIG(4), .STABLE_CNT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .seg(seg), .dig_sel(dig_sel),
`ifdef SEG7_DP_EN
    .dp(dp), .dp_mask(dpm_o[0]),
`endif
    .frame_valid(fv_o[0]), .bcd_out(bcd_o[0]), .blank_mask(blank_o[0]), .err_mask(err_o[0]));

  seg7_scan_decoder #(.NDIG(4), .STABLE_CNT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .seg(seg), .dig_sel(dig_sel),
`ifdef SEG7_DP_EN
    .dp(dp), .dp_mask(dpm_o[1]),
`endif
    .frame_valid(fv_o[1]), .bcd_out(bcd_o[1]), .blank_mask(blank_o[1]), .err_mask(err_o[1]));

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] pats [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110010, 7'b1111111, 7'b1111011};

  // Reference model state
  int         stab [2] = '{3, 1};
  logic [6:0] m_prev_seg;
  logic [3:0] m_prev_sel;
  int         run;
  logic [3:0] cap [2];
  int         stg_val [2][4];
  bit         pub [2];
  bit         exp_fv [2];
  logic [15:0] exp_bcd [2];
  logic [3:0]  exp_blank [2];
  logic [3:0]  exp_err [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic int dec(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (pats[i] == p) return i;
    if (p == 7'd0) return 15;
    return 14;
  endfunction

  task automatic model_reset();
    m_prev_seg = 7'd0; m_prev_sel = 4'd0; run = 0;
    for (int i = 0; i < 2; i++) begin
      cap[i] = 4'd0; pub[i] = 1'b0; exp_fv[i] = 1'b0;
      exp_bcd[i] = 16'd0; exp_blank[i] = 4'd0; exp_err[i] = 4'd0;
      for (int k = 0; k < 4; k++) stg_val[i][k] = 0;
    end
  endtask

  task automatic model_step(input logic [6:0] s, input logic [3:0] d);
    bit onehot;
    bit acc;
    int k;
    onehot = ($countones(d) == 1);
    if (onehot && s == m_prev_seg && d == m_prev_sel) run++;
    else if (onehot) run = 1;
    else run = 0;
    m_prev_seg = s; m_prev_sel = d;
    k = 0;
    for (int j = 0; j < 4; j++) if (d[j]) k = j;
    for (int i = 0; i < 2; i++) begin
      acc = onehot && (run == stab[i]);
      if (acc) stg_val[i][k] = dec(s);
      if (pub[i]) begin
        cap[i] = acc ? d : 4'd0;
        pub[i] = 1'b0;
        exp_fv[i] = 1'b0;
      end else begin
        if (acc) cap[i] = cap[i] | d;
        if (acc && cap[i] == 4'hF) begin
          pub[i] = 1'b1;
          exp_fv[i] = 1'b1;
          for (int j = 0; j < 4; j++) begin
            exp_bcd[i][4*j +: 4] = 4'(stg_val[i][j]);
            exp_blank[i][j] = (stg_val[i][j] == 15);
            exp_err[i][j]   = (stg_val[i][j] == 14);
          end
        end else begin
          exp_fv[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_outputs(input string ctx);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s_fv%0d", ctx, stab[i]),    32'(fv_o[i]),    32'(exp_fv[i]));
      check_eq($sformatf("%s_bcd%0d", ctx, stab[i]),   32'(bcd_o[i]),   32'(exp_bcd[i]));
      check_eq($sformatf("%s_blank%0d", ctx, stab[i]), 32'(blank_o[i]), 32'(exp_blank[i]));
      check_eq($sformatf("%s_err%0d", ctx, stab[i]),   32'(err_o[i]),   32'(exp_err[i]));
    end
  endtask

  task automatic step(input logic [6:0] s, input logic [3:0] d);
    seg = s; dig_sel = d;
    @(posedge clk);
    model_step(s, d);
    #1;
    check_outputs("step");
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
    for (int c = 0; c < n; c++) step(s, d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    seg = 7'b1111111; dig_sel = 4'b0100;
    #1;
    model_reset();
    check_outputs("rst");
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst_hold");
    rst_n = 1'b1;
  endtask

  task automatic scan(input int v0, input int v1, input int v2, input int v3, input int n);
    int v [4];
    v = '{v0, v1, v2, v3};
    for (int k = 0; k < 4; k++) begin
      logic [6:0] p;
      if (v[k] < 10) p = pats[v[k]];
      else if (v[k] == 15) p = 7'b0000000;
      else p = 7'b1010101;
      hold(p, 4'(1 << k), n);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    // Only two samples: too short for STABLE_CNT=3.
    hold(pats[1], 4'b0001, 2);
    check_eq("short_hold_fv", 32'(fv_o[0]), 32'd0);
    step(7'd0, 4'd0);

    scan(1, 2, 3, 4, 3);
    check_eq("scan1234_fv", 32'(fv_o[0]), 32'd1);
    check_eq("scan1234_bcd", 32'(bcd_o[0]), 32'h4321);
    check_eq("scan1234_blank", 32'(blank_o[0]), 32'd0);
    check_eq("scan1234_err", 32'(err_o[0]), 32'd0);
    step(7'd0, 4'd0);
    check_eq("pulse_one_cycle", 32'(fv_o[0]), 32'd0);

    hold(pats[0], 4'b0001, 20);
    check_eq("held_no_frame", 32'(fv_o[0]), 32'd0);

    scan(1, 2, 15, 14, 3);
    check_eq("blankerr_bcd", 32'(bcd_o[0]), 32'hEF21);
    check_eq("blankerr_blank", 32'(blank_o[0]), 32'b0100);
    check_eq("blankerr_err", 32'(err_o[0]), 32'b1000);

    // Glitched strobes interleaved with a re-scan.
    hold(pats[5], 4'b0001, 3);
    step(pats[5], 4'b0011);
    hold(pats[6], 4'b0010, 2);
    step(pats[6], 4'b0011);
    hold(pats[6], 4'b0010, 3);
    hold(pats[7], 4'b0100, 3);
    hold(pats[8], 4'b1000, 3);
    check_eq("glitch_bcd", 32'(bcd_o[0]), 32'h8765);

    // Back-to-back single-cycle scans exercise acceptance during PUBLISH on STABLE_CNT=1.
    scan(9, 8, 7, 6, 1);
    scan(0, 1, 2, 3, 1);
    scan(4, 5, 6, 7, 1);

    // Reset mid-frame: partial captures must not resurface.
    hold(pats[2], 4'b0001, 3);
    hold(pats[3], 4'b0010, 3);
    do_reset();
    hold(pats[4], 4'b0100, 3);
    hold(pats[5], 4'b1000, 3);
    hold(7'd0, 4'd0, 8);
    check_eq("no_stale_publish", 32'(fv_o[0]), 32'd0);

    // Randomised bus traffic.
    for (int r = 0; r < 400; r++) begin
      logic [6:0] p;
      logic [3:0] d;
      int sel_kind, seg_kind;
      sel_kind = $urandom_range(0, 99);
      seg_kind = $urandom_range(0, 99);
      if (sel_kind < 85) d = 4'(1 << $urandom_range(0, 3));
      else d = 4'($urandom_range(0, 15));
      if (seg_kind < 70) p = pats[$urandom_range(0, 9)];
      else if (seg_kind < 80) p = 7'd0;
      else p = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 149) == 0) do_reset();
      hold(p, d, $urandom_range(1, 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Reads a multiplexed 7-segment display bus: segment lines plus a one-hot digit strobe.
- Recovers the BCD digit shown in each position, so it is the reader for the BCD-to-segment encoder.
- Uses it for display loopback self-check and for capturing external panel readouts.
- Publishes a full multi-digit frame with blank/error masks once every digit position has been stably observed.

Parameters:
- NDIG, 4, number of digit positions (strobe width).
- STABLE_CNT, 3, consecutive identical samples required before a digit is accepted (range 1..15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg  in  7  segment pattern; bit6=a … bit0=g; 1 = segment lit.
- dig_sel  in  NDIG  digit strobe; active high; must be one-hot to be sampled.
- frame_valid  out  1  one-cycle pulse when a new frame is published.
- bcd_out  out  4*NDIG  decoded digits; nibble k belongs to dig_sel[k].
- blank_mask  out  NDIG  bit k=1: position k was all segments off.
- err_mask  out  NDIG  bit k=1: position k showed an unrecognised pattern.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - frame_valid=0, bcd_out=0, blank_mask=0, err_mask=0.
  - Stability counter=0, previous-sample registers=0, captured flags=0, accepted flag=0.
  - FSM returns to COLLECT.
  - Reset mid-frame discards all partial captures.
- Decode table (exact), pattern -> nibble:
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4.
  - 1011011->5, 1011111->6, 1110010->7, 1111111->8, 1111011->9.
  - 0000000 -> nibble 4'hF, blank bit set.
  - Any other pattern -> nibble 4'hE, err bit set.
- Sampling, every cycle:
  - If dig_sel is zero or not one-hot, the stability counter clears to 0, the accepted flag clears, and nothing is captured.
  - If {seg,dig_sel} equals the previous cycle's value and is one-hot, the counter increments, saturating at STABLE_CNT-1. Otherwise the counter loads 0 and the accepted flag clears.
  - Acceptance occurs on the edge where the counter is already STABLE_CNT-1 (STABLE_CNT=1: the first valid sample) and the accepted flag is 0.
  - On acceptance, the decoded nibble, blank bit and err bit are written into staging slot k, captured[k] is set, and the accepted flag is set.
  - A held strobe is accepted once only. A new acceptance needs a change in seg or dig_sel.
  - A repeat acceptance of an already-captured slot in the same frame overwrites its staging value (latest wins).
- FSM:
  - COLLECT: accumulates captures. When the acceptance fills the last zero bit of captured, go to PUBLISH on the same edge.
  - PUBLISH (exactly 1 cycle): frame_valid=1; bcd_out/blank_mask/err_mask present the staging contents; captured clears to 0 at the end of the cycle; return to COLLECT.
  - An acceptance during the PUBLISH cycle updates staging and sets its captured bit for the next frame. That bit survives the clear.
- Outputs:
  - Registered, held constant between publications.
  - Change only on the edge that enters PUBLISH.
- Latency: last digit's first stable sample in cycle t -> frame_valid high in cycle t+STABLE_CNT.

Optional Feature:
- SEG7_DP_EN defined:
  - Adds input dp (1 bit, decimal point, active high) and output dp_mask (NDIG).
  - dp is included in the stability comparison and captured per slot.
  - dp does not affect decode, blank or err.
  - dp_mask resets to 0 and updates with the other outputs.
- Undefined: neither port exists; behaviour otherwise identical.

Test Plan:
- Reset check: hold rst_n=0 with active stimulus -> all outputs 0. Release, drive dig_sel=0001, seg=0110000 for 2 cycles only -> no acceptance, frame_valid stays 0.
- Scan digits 1,2,3,4 (dig_sel 0001..1000, 3 cycles each, NDIG=4, STABLE_CNT=3) -> one frame_valid pulse 3 cycles after the last digit starts; bcd_out=16'h4321, blank_mask=0, err_mask=0.
- Same scan with position 2 = 0000000 and position 3 = 1010101 -> bcd_out=16'hEF21, blank_mask=0100, err_mask=1000.
- Hold dig_sel=0001, seg=1111110 for 20 cycles -> accepted once, captured=0001, no frame_valid.
- Glitch injection: dig_sel=0011 for one cycle between valid strobes -> counter clears, that sample is ignored, frame still correct after re-scan.
- Continuous rescan with new values -> consecutive frames; an acceptance landing in the PUBLISH cycle appears in the next frame. Assert rst_n low mid-frame -> no stale publish after release.
